// File: rtl/sized_bypass_fifo_pkg.sv
// Shared types and defaults for the sized bypass FIFO.
// Default geometry and the per-cycle operation encoding.
package sized_bypass_fifo_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_PTR_W = 2;
  localparam int DEF_CNT_W = 3;

  // Effective operation after legality filtering.
  // Encoded as {enq, deq}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_DEQ  = 2'b01,
    OP_ENQ  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sized_fifo_regfile.sv
// Storage for the sized bypass FIFO: one sync write port, one async read port.
// Ports: CLK, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (read).
module sized_fifo_regfile #(
  parameter int p1width     = 8,
  parameter int p2depth     = 4,
  parameter int p3ptr_width = 2
) (
  input  logic                   CLK,
  input  logic                   we_i,
  input  logic [p3ptr_width-1:0] waddr_i,
  input  logic [p1width-1:0]     wdata_i,
  input  logic [p3ptr_width-1:0] raddr_i,
  output logic [p1width-1:0]     rdata_o
);

  logic [p1width-1:0] mem_q [p2depth];

  always_ff @(posedge CLK) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sized_bypass_fifo.sv
// Depth-N data FIFO whose empty state passes ENQ data straight to D_OUT.
// Ports: CLK, RST_N, D_IN/ENQ/FULL_N (producer), D_OUT/DEQ/EMPTY_N (consumer), CLR.
module sized_bypass_fifo
  import sized_bypass_fifo_pkg::*;
#(
  parameter int p1width      = DEF_WIDTH,
  parameter int p2depth      = DEF_DEPTH,
  parameter int p3ptr_width  = DEF_PTR_W,
  parameter int p4cntr_width = DEF_CNT_W
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [p1width-1:0] D_IN,
  input  logic               ENQ,
  output logic               FULL_N,
  output logic [p1width-1:0] D_OUT,
  input  logic               DEQ,
  output logic               EMPTY_N,
  input  logic               CLR
);

  localparam logic [p3ptr_width-1:0] PTR_LAST =
    p3ptr_width'(p2depth - 1);
  localparam logic [p4cntr_width-1:0] CNT_LAST =
    p4cntr_width'(p2depth - 1);
  localparam logic [p4cntr_width-1:0] CNT_ONE =
    p4cntr_width'(1);

  logic [p3ptr_width-1:0]  head_q, head_d;
  logic [p3ptr_width-1:0]  tail_q, tail_d;
  logic [p4cntr_width-1:0] count_q, count_d;
  logic                    not_empty_q, not_empty_d;
  logic                    not_full_q, not_full_d;

  logic               bypass;
  logic               do_enq;
  logic               do_deq;
  logic               we;
  logic [p1width-1:0] rdata;
  logic [p3ptr_width-1:0] head_inc;
  logic [p3ptr_width-1:0] tail_inc;
  fifo_op_e           op;

  // Empty with ENQ+DEQ: data flows through without touching storage.
  assign bypass = ENQ && DEQ && !not_empty_q;
  // Enqueue-when-full is dropped even with DEQ, keeping FULL_N registered.
  assign do_enq = ENQ && not_full_q && !bypass;
  assign do_deq = DEQ && not_empty_q;
  assign we     = do_enq && !CLR;
  assign op     = fifo_op_e'({do_enq, do_deq});

  assign head_inc = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
  assign tail_inc = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;

  assign FULL_N  = not_full_q;
  assign EMPTY_N = not_empty_q || ENQ;
  assign D_OUT   = not_empty_q ? rdata : D_IN;

  sized_fifo_regfile #(
    .p1width    (p1width),
    .p2depth    (p2depth),
    .p3ptr_width(p3ptr_width)
  ) u_regfile (
    .CLK    (CLK),
    .we_i   (we),
    .waddr_i(tail_q),
    .wdata_i(D_IN),
    .raddr_i(head_q),
    .rdata_o(rdata)
  );

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    not_empty_d = not_empty_q;
    not_full_d  = not_full_q;
    if (CLR) begin
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
      not_empty_d = 1'b0;
      not_full_d  = 1'b1;
    end else begin
      unique case (op)
        OP_BOTH: begin
          head_d = head_inc;
          tail_d = tail_inc;
        end
        OP_ENQ: begin
          tail_d      = tail_inc;
          count_d     = count_q + 1'b1;
          not_empty_d = 1'b1;
          not_full_d  = (count_q != CNT_LAST);
        end
        OP_DEQ: begin
          head_d      = head_inc;
          count_d     = count_q - 1'b1;
          not_empty_d = (count_q != CNT_ONE);
          not_full_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      not_empty_q <= 1'b0;
      not_full_q  <= 1'b1;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      not_empty_q <= not_empty_d;
      not_full_q  <= not_full_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge CLK) begin
    if (RST_N && DEQ && !EMPTY_N)
      $warning("Dequeuing from empty fifo");
    if (RST_N && ENQ && !FULL_N)
      $warning("Enqueuing to a full fifo");
  end
`endif

endmodule

// File: tb/tb_sized_bypass_fifo.sv
// Directed bench for sized_bypass_fifo with a queue-based scoreboard.
// Checks FULL_N, EMPTY_N and D_OUT every cycle against a reference queue.
module tb_sized_bypass_fifo;

  localparam int DEPTH = 4;

  logic       CLK;
  logic       RST_N;
  logic [7:0] D_IN;
  logic       ENQ;
  logic       FULL_N;
  logic [7:0] D_OUT;
  logic       DEQ;
  logic       EMPTY_N;
  logic       CLR;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb [$];

  sized_bypass_fifo #(
    .p1width     (8),
    .p2depth     (DEPTH),
    .p3ptr_width (2),
    .p4cntr_width(3)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .D_IN   (D_IN),
    .ENQ    (ENQ),
    .FULL_N (FULL_N),
    .D_OUT  (D_OUT),
    .DEQ    (DEQ),
    .EMPTY_N(EMPTY_N),
    .CLR    (CLR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive, check combinational outputs, clock, update model.
  task automatic cyc(input string tag,
                     input logic enq,
                     input logic deq,
                     input logic [7:0] din,
                     input logic clr = 1'b0,
                     input logic rstn = 1'b1);
    logic [7:0] exp_out;
    logic       full;
    logic       empty;
    ENQ   = enq;
    DEQ   = deq;
    D_IN  = din;
    CLR   = clr;
    RST_N = rstn;
    #2;
    full    = (sb.size() == DEPTH);
    empty   = (sb.size() == 0);
    exp_out = empty ? din : sb[0];
    check({tag, ".full_n"}, {7'd0, FULL_N}, {7'd0, !full});
    check({tag, ".empty_n"}, {7'd0, EMPTY_N},
          {7'd0, (!empty || enq)});
    check({tag, ".d_out"}, D_OUT, exp_out);
    @(posedge CLK);
    #1;
    if (!rstn || clr) begin
      sb.delete();
    end else begin
      if (enq && !full && !(deq && empty))
        sb.push_back(din);
      if (deq && !empty)
        void'(sb.pop_front());
    end
  endtask

  initial begin
    RST_N = 1'b0;
    ENQ   = 1'b0;
    DEQ   = 1'b0;
    CLR   = 1'b0;
    D_IN  = 8'h00;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;

    // Idle after reset: D_OUT follows D_IN.
    cyc("idle", 1'b0, 1'b0, 8'h5A);
    // Bypass through an empty FIFO.
    cyc("bypass", 1'b1, 1'b1, 8'h33);
    cyc("post_bypass", 1'b0, 1'b0, 8'h77);

    // Fill, overflow attempt, drain.
    for (int i = 1; i <= 4; i++)
      cyc("fill", 1'b1, 1'b0, 8'(i));
    cyc("ovf", 1'b1, 1'b0, 8'h05);
    for (int i = 0; i < 4; i++)
      cyc("drain", 1'b0, 1'b1, 8'hEE);
    cyc("drained", 1'b0, 1'b0, 8'hC3);

    // Hold two entries and stream through, wrapping pointers.
    cyc("pre_a0", 1'b1, 1'b0, 8'hA0);
    cyc("pre_a1", 1'b1, 1'b0, 8'hA1);
    for (int i = 0; i < 10; i++)
      cyc("wrap", 1'b1, 1'b1, 8'(8'hB0 + i));
    cyc("wrap_d0", 1'b0, 1'b1, 8'h00);
    cyc("wrap_d1", 1'b0, 1'b1, 8'h00);
    cyc("wrap_end", 1'b0, 1'b0, 8'h11);

    // Full with ENQ+DEQ: dequeue only.
    for (int i = 1; i <= 4; i++)
      cyc("fill2", 1'b1, 1'b0, 8'(8'hC0 + i));
    cyc("full_both", 1'b1, 1'b1, 8'hD0);
    cyc("after_fb", 1'b0, 1'b0, 8'h22);

    // CLR mid-operation with ENQ asserted.
    cyc("clr", 1'b1, 1'b0, 8'hE0, 1'b1);
    cyc("after_clr", 1'b0, 1'b0, 8'h44);
    cyc("clr_byp", 1'b1, 1'b1, 8'h45);

    // Same again using reset.
    for (int i = 1; i <= 3; i++)
      cyc("fill3", 1'b1, 1'b0, 8'(8'hF0 + i));
    cyc("rst", 1'b1, 1'b0, 8'hE1, 1'b0, 1'b0);
    cyc("after_rst", 1'b0, 1'b0, 8'h66);
    cyc("rst_enq", 1'b1, 1'b0, 8'h67);
    cyc("rst_deq", 1'b0, 1'b1, 8'h68);
    cyc("final", 1'b0, 1'b0, 8'h69);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
